// File: rtl/raiz_iterativa.sv
// Iterative restoring integer square root, one result bit per clock.
// Optional macro RAIZ_RESTO_EN adds the Resto output (Op_A - Resultado^2).
module raiz_iterativa #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             INIT,
    input  logic [WIDTH-1:0] Op_A,
`ifdef RAIZ_RESTO_EN
    output logic [WIDTH/2:0] Resto,
`endif
    output logic [WIDTH-1:0] Resultado,
    output logic             DONE
);

    localparam int HW = WIDTH / 2;
    localparam int RW = HW + 2;
    localparam int CW = (HW > 1) ? $clog2(HW) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(HW - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    state_t           state_q, state_d;
    logic             init_q, init_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [HW-1:0]    root_q, root_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             done_q, done_d;
`ifdef RAIZ_RESTO_EN
    logic [HW:0]      resto_q, resto_d;
`endif

    logic          start;
    logic [RW-1:0] rem_shift;
    logic [RW-1:0] trial;
    logic [RW-1:0] rem_next;
    logic [HW-1:0] root_next;

    always_comb begin
        state_d = state_q;
        init_d  = INIT;
        opnd_d  = opnd_q;
        rem_d   = rem_q;
        root_d  = root_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        done_d  = done_q;
`ifdef RAIZ_RESTO_EN
        resto_d = resto_q;
`endif
        start = INIT & ~init_q;

        // One restoring step: bring down two radicand bits, try to subtract 4*root+1.
        rem_shift = RW'({rem_q, opnd_q[WIDTH-1:WIDTH-2]});
        trial     = {root_q, 2'b01};
        if (rem_shift >= trial) begin
            rem_next  = rem_shift - trial;
            root_next = HW'({root_q, 1'b1});
        end else begin
            rem_next  = rem_shift;
            root_next = HW'({root_q, 1'b0});
        end

        case (state_q)
            IDLE, FIN: begin
                if (start) begin
                    opnd_d  = Op_A;
                    rem_d   = '0;
                    root_d  = '0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                opnd_d = {opnd_q[WIDTH-3:0], 2'b00};
                rem_d  = rem_next;
                root_d = root_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    res_d   = {{(WIDTH - HW){1'b0}}, root_next};
                    done_d  = 1'b1;
                    state_d = FIN;
`ifdef RAIZ_RESTO_EN
                    resto_d = rem_next[HW:0];
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q <= IDLE;
            init_q  <= 1'b0;
            opnd_q  <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
`ifdef RAIZ_RESTO_EN
            resto_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            opnd_q  <= opnd_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            done_q  <= done_d;
`ifdef RAIZ_RESTO_EN
            resto_q <= resto_d;
`endif
        end
    end

    assign Resultado = res_q;
    assign DONE      = done_q;
`ifdef RAIZ_RESTO_EN
    assign Resto     = resto_q;
`endif

endmodule

// File: tb/tb_raiz_iterativa.sv
// Self-checking bench for raiz_iterativa: cycle-level behavioural model plus directed
// literal checks and randomized INIT/Op_A/reset traffic.
module tb_raiz_iterativa;

    localparam int WIDTH = 16;
    localparam int HW    = WIDTH / 2;

    logic             CLK;
    logic             reset;
    logic             INIT;
    logic [WIDTH-1:0] Op_A;
    logic [WIDTH-1:0] Resultado;
    logic             DONE;
`ifdef RAIZ_RESTO_EN
    logic [HW:0]      Resto;
`endif

    int num_checks = 0;
    int num_errors = 0;

    raiz_iterativa #(.WIDTH(WIDTH)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .INIT      (INIT),
        .Op_A      (Op_A),
`ifdef RAIZ_RESTO_EN
        .Resto     (Resto),
`endif
        .Resultado (Resultado),
        .DONE      (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic longint isqrt(input longint v);
        longint r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: a start launches a computation that finishes HW edges later.
    logic   m_valid = 1'b0;
    logic   m_prev, m_busy, m_done;
    int     m_left;
    longint m_op, m_res, m_resto;

    always @(posedge CLK) begin
        if (!reset) begin
            m_valid <= 1'b1;
            m_prev  <= 1'b0;
            m_busy  <= 1'b0;
            m_left  <= 0;
            m_done  <= 1'b0;
            m_res   <= 0;
            m_resto <= 0;
        end else begin
            m_prev <= INIT;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_busy  <= 1'b0;
                    m_done  <= 1'b1;
                    m_res   <= isqrt(m_op);
                    m_resto <= m_op - isqrt(m_op) * isqrt(m_op);
                end
                m_left <= m_left - 1;
            end else if (INIT && !m_prev) begin
                m_op   <= longint'(Op_A);
                m_busy <= 1'b1;
                m_left <= HW;
                m_done <= 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        if (m_valid) begin
            checkOutput("model_DONE", longint'(DONE), longint'(m_done));
            checkOutput("model_Resultado", longint'(Resultado), m_res);
`ifdef RAIZ_RESTO_EN
            checkOutput("model_Resto", longint'(Resto), m_resto);
`endif
        end
    end

    task automatic applyStimulus(input logic rst_n, input logic init, input logic [WIDTH-1:0] op, input int edges);
        reset = rst_n;
        INIT  = init;
        Op_A  = op;
        repeat (edges) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic runCompute(input string name, input logic [WIDTH-1:0] op, input longint exp_root);
        applyStimulus(1'b1, 1'b0, op, 1);
        applyStimulus(1'b1, 1'b1, op, HW + 1);
        checkOutput({name, "_DONE"}, longint'(DONE), 1);
        checkOutput({name, "_Resultado"}, longint'(Resultado), exp_root);
    endtask

    initial begin
        reset = 1'b0;
        INIT  = 1'b0;
        Op_A  = '0;
        applyStimulus(1'b0, 1'b0, '0, 2);
        checkOutput("reset_DONE", longint'(DONE), 0);
        checkOutput("reset_Resultado", longint'(Resultado), 0);

        runCompute("zero", 16'd0, 0);
        runCompute("sq144", 16'd144, 12);
        runCompute("op15", 16'd15, 3);
        runCompute("max", 16'hFFFF, 255);

        // Retrigger and operand change mid-computation must be ignored.
        applyStimulus(1'b1, 1'b0, 16'd200, 1);
        applyStimulus(1'b1, 1'b1, 16'd200, 2);
        applyStimulus(1'b1, 1'b0, 16'd200, 1);
        applyStimulus(1'b1, 1'b1, 16'd9, 6);
        checkOutput("midcalc_DONE", longint'(DONE), 1);
        checkOutput("midcalc_Resultado", longint'(Resultado), 14);

        // INIT held high: one computation only.
        applyStimulus(1'b1, 1'b0, 16'd81, 1);
        applyStimulus(1'b1, 1'b1, 16'd81, HW + 1);
        checkOutput("held_Resultado", longint'(Resultado), 9);
        applyStimulus(1'b1, 1'b1, 16'd81, 30 - (HW + 1));
        checkOutput("held_DONE", longint'(DONE), 1);
        applyStimulus(1'b1, 1'b0, 16'd81, 1);
        applyStimulus(1'b1, 1'b1, 16'd81, 1);
        checkOutput("restart_DONE_low", longint'(DONE), 0);
        applyStimulus(1'b1, 1'b1, 16'd81, HW);

        // Reset mid-computation, released with INIT still high.
        applyStimulus(1'b1, 1'b0, 16'd1000, 1);
        applyStimulus(1'b1, 1'b1, 16'd1000, 4);
        applyStimulus(1'b0, 1'b1, 16'd1000, 1);
        checkOutput("midreset_DONE", longint'(DONE), 0);
        checkOutput("midreset_Resultado", longint'(Resultado), 0);
        applyStimulus(1'b1, 1'b1, 16'd1000, HW + 1);
        checkOutput("postreset_DONE", longint'(DONE), 1);
        checkOutput("postreset_Resultado", longint'(Resultado), 31);

        for (int i = 0; i < 1500; i++) begin
            logic [WIDTH-1:0] op;
            logic             init;
            logic             rst_n;
            case ($urandom_range(0, 7))
                0:       op = '0;
                1:       op = '1;
                default: op = WIDTH'($urandom);
            endcase
            init  = ($urandom_range(0, 5) == 0) ? ~INIT : INIT;
            rst_n = ($urandom_range(0, 199) != 0);
            applyStimulus(rst_n, init, op, 1);
        end

        applyStimulus(1'b1, 1'b0, '0, 2);
        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
